// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: ALU results go straight through, load results are buffered
// in a small FIFO and drained when the ALU is idle or has starved the buffer too long.
module writeback_arbiter #(
    parameter int unsigned ADDR_SIZE    = 5,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDR_SIZE-1:0]        alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [ADDR_SIZE-1:0]        mem_rd,
    input  logic [XLEN-1:0]             mem_data,
    output logic                        write_enable,
    output logic [ADDR_SIZE-1:0]        write_addr,
    output logic [XLEN-1:0]             write_data,
    output logic [(1<<ADDR_SIZE)-1:0]   pending
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_SIZE-1:0] rd_mem   [FIFO_DEPTH];
    logic [XLEN-1:0]      data_mem [FIFO_DEPTH];

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [XLEN-1:0]      data_q, data_d;

    logic alu_hs;
    logic push;
    logic pop;
    logic empty;

    assign empty     = (count_q == '0);
    assign mem_ready = (count_q < CW'(FIFO_DEPTH));
    assign alu_ready = (starve_q < SW'(STARVE_LIMIT));
    assign alu_hs    = alu_valid & alu_ready;
    assign push      = mem_valid & mem_ready;
    // ALU always wins a handshake; the buffer drains only on edges the ALU leaves free.
    assign pop       = ~alu_hs & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (alu_hs) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (alu_hs) begin
            we_d   = (alu_rd != '0);
            addr_d = alu_rd;
            data_d = alu_data;
        end else if (pop) begin
            we_d   = (rd_mem[rd_ptr_q] != '0);
            addr_d = rd_mem[rd_ptr_q];
            data_d = data_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset: entries are only observed below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= mem_rd;
            data_mem[wr_ptr_q] <= mem_data;
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
            if (k < int'(count_q)) begin
                pending[rd_mem[rd_ptr_q + PW'(k)]] = 1'b1;
            end
        end
    end

    assign write_enable = we_q;
    assign write_addr   = addr_q;
    assign write_data   = data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter with default parameters.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (write_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_we: got %b expected 0", write_enable);
        end
        n_checks++;
        if (write_addr !== 5'd0 || write_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_port: got %0d/%h expected 0/0", write_addr, write_data);
        end
        n_checks++;
        if (pending !== 32'd0) begin
            n_fail++; $display("FAIL reset_pending: got %h expected 0", pending);
        end
        n_checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b%b expected 11", mem_ready, alu_ready);
        end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        n_checks++;
        if (write_enable !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_write: got we=%b addr=%0d data=%h expected 1/5/deadbeef",
                     write_enable, write_addr, write_data);
        end
        tick();
        n_checks++;
        if (write_enable !== 1'b0 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_hold: got we=%b addr=%0d data=%h expected 0/5/deadbeef",
                     write_enable, write_addr, write_data);
        end
    endtask

    task automatic test_single_load();
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
        tick();
        idle_inputs();
        n_checks++;
        if (pending !== 32'h80 || write_enable !== 1'b0) begin
            n_fail++; $display("FAIL load_pending: got %h we=%b expected 00000080 we=0",
                               pending, write_enable);
        end
        tick();
        n_checks++;
        if (write_enable !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL load_write: got we=%b addr=%0d data=%h expected 1/7/1234",
                     write_enable, write_addr, write_data);
        end
        n_checks++;
        if (pending !== 32'd0) begin
            n_fail++; $display("FAIL load_pending_clear: got %h expected 0", pending);
        end
        tick();
    endtask

    task automatic test_buffer_full();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h11;
        tick();
        n_checks++;
        if (write_enable !== 1'b1 || write_addr !== 5'd20 || mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_first: got we=%b addr=%0d mrdy=%b expected 1/20/1",
                               write_enable, write_addr, mem_ready);
        end
        mem_rd = 5'd2; mem_data = 32'h22;
        tick();
        mem_rd = 5'd3; mem_data = 32'h33;
        n_checks++;
        if (mem_ready !== 1'b0 || pending !== 32'h6) begin
            n_fail++; $display("FAIL full_ready: got mrdy=%b pending=%h expected 0/00000006",
                               mem_ready, pending);
        end
        tick();
        tick();
        n_checks++;
        if (mem_ready !== 1'b0 || alu_ready !== 1'b1 || pending !== 32'h6) begin
            n_fail++; $display("FAIL full_hold: got mrdy=%b ardy=%b pending=%h expected 0/1/6",
                               mem_ready, alu_ready, pending);
        end
        tick();
        n_checks++;
        if (alu_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_starve: got ardy=%b expected 0", alu_ready);
        end
        tick();
        n_checks++;
        if (write_enable !== 1'b1 || write_addr !== 5'd1 || write_data !== 32'h11) begin
            n_fail++; $display("FAIL full_pop1: got we=%b addr=%0d data=%h expected 1/1/11",
                               write_enable, write_addr, write_data);
        end
        n_checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b1 || pending !== 32'h4) begin
            n_fail++; $display("FAIL full_after_pop: got mrdy=%b ardy=%b pending=%h expected 1/1/4",
                               mem_ready, alu_ready, pending);
        end
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        n_checks++;
        if (write_addr !== 5'd20 || pending !== 32'hC) begin
            n_fail++; $display("FAIL full_push3: got addr=%0d pending=%h expected 20/0000000c",
                               write_addr, pending);
        end
        tick();
        n_checks++;
        if (write_enable !== 1'b1 || write_addr !== 5'd2 || write_data !== 32'h22) begin
            n_fail++; $display("FAIL full_pop2: got we=%b addr=%0d data=%h expected 1/2/22",
                               write_enable, write_addr, write_data);
        end
        tick();
        n_checks++;
        if (write_enable !== 1'b1 || write_addr !== 5'd3 || write_data !== 32'h33) begin
            n_fail++; $display("FAIL full_pop3: got we=%b addr=%0d data=%h expected 1/3/33",
                               write_enable, write_addr, write_data);
        end
        tick();
        n_checks++;
        if (write_enable !== 1'b0 || pending !== 32'd0) begin
            n_fail++; $display("FAIL full_drain: got we=%b pending=%h expected 0/0",
                               write_enable, pending);
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h100;
        mem_valid = 1'b1; mem_rd = 5'd9;  mem_data = 32'h99;
        tick();
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'h200 + 32'(i);
            n_checks++;
            if (alu_ready !== 1'b1) begin
                n_fail++; $display("FAIL starve_ready_%0d: got %b expected 1", i, alu_ready);
            end
            tick();
            n_checks++;
            if (write_enable !== 1'b1 || write_addr !== 5'd12 ||
                write_data !== 32'h200 + 32'(i) || pending !== 32'h200) begin
                n_fail++;
                $display("FAIL starve_alu_%0d: got we=%b addr=%0d data=%h pending=%h", i,
                         write_enable, write_addr, write_data, pending);
            end
        end
        n_checks++;
        if (alu_ready !== 1'b0) begin
            n_fail++; $display("FAIL starve_block: got ardy=%b expected 0", alu_ready);
        end
        tick();
        n_checks++;
        if (write_enable !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'h99) begin
            n_fail++; $display("FAIL starve_pop: got we=%b addr=%0d data=%h expected 1/9/99",
                               write_enable, write_addr, write_data);
        end
        n_checks++;
        if (alu_ready !== 1'b1 || pending !== 32'd0) begin
            n_fail++; $display("FAIL starve_clear: got ardy=%b pending=%h expected 1/0",
                               alu_ready, pending);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h5;
        mem_valid = 1'b1; mem_rd = 5'd8;  mem_data = 32'hA;
        tick();
        mem_data = 32'hB;
        tick();
        idle_inputs();
        n_checks++;
        if (pending !== 32'h100) begin
            n_fail++; $display("FAIL dup_pending: got %h expected 00000100", pending);
        end
        tick();
        n_checks++;
        if (write_addr !== 5'd8 || write_data !== 32'hA || pending !== 32'h100) begin
            n_fail++; $display("FAIL dup_first: got addr=%0d data=%h pending=%h expected 8/a/100",
                               write_addr, write_data, pending);
        end
        tick();
        n_checks++;
        if (write_enable !== 1'b1 || write_addr !== 5'd8 || write_data !== 32'hB) begin
            n_fail++; $display("FAIL dup_second: got we=%b addr=%0d data=%h expected 1/8/b",
                               write_enable, write_addr, write_data);
        end
        tick();
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        n_checks++;
        if (alu_ready !== 1'b1) begin
            n_fail++; $display("FAIL x0_ready: got %b expected 1", alu_ready);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (write_enable !== 1'b0) begin
            n_fail++; $display("FAIL x0_alu: got we=%b expected 0", write_enable);
        end
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h66;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (write_enable !== 1'b0 || mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL x0_load: got we=%b mrdy=%b expected 0/1",
                               write_enable, mem_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 32'hF;
        mem_valid = 1'b1; mem_rd = 5'd4;  mem_data = 32'h44;
        tick();
        mem_rd = 5'd6; mem_data = 32'h66;
        tick();
        idle_inputs();
        n_checks++;
        if (pending !== 32'h50 || write_enable !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got pending=%h we=%b expected 00000050/1",
                               pending, write_enable);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (pending !== 32'd0 || write_enable !== 1'b0 || mem_ready !== 1'b1 ||
            alu_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: got pending=%h we=%b mrdy=%b ardy=%b",
                               pending, write_enable, mem_ready, alu_ready);
        end
        tick();
        #1 rst = 1'b1;
        tick();
        n_checks++;
        if (write_enable !== 1'b0 || pending !== 32'd0) begin
            n_fail++; $display("FAIL mid_release1: got we=%b pending=%h expected 0/0",
                               write_enable, pending);
        end
        tick();
        n_checks++;
        if (write_enable !== 1'b0) begin
            n_fail++; $display("FAIL mid_release2: got we=%b expected 0", write_enable);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        test_reset();
        rst = 1'b1;
        test_single_alu();
        test_single_load();
        test_buffer_full();
        test_starvation();
        test_back_to_back();
        test_x0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 5, register address width.
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 Parameter FIFO_DEPTH, default 2, load-result buffer entries (power of two, >=2).
REQ-004 Parameter STARVE_LIMIT, default 4, max consecutive ALU wins while the buffer holds data.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 alu_valid  input  1  ALU result offered.
REQ-008 alu_ready  output  1  arbiter accepts the ALU result this cycle.
REQ-009 alu_rd  input  ADDR_SIZE  ALU destination register.
REQ-010 alu_data  input  XLEN  ALU result.
REQ-011 mem_valid  input  1  load result offered.
REQ-012 mem_ready  output  1  buffer has space.
REQ-013 mem_rd  input  ADDR_SIZE  load destination register.
REQ-014 mem_data  input  XLEN  load result.
REQ-015 write_enable  output  1  register-file write strobe.
REQ-016 write_addr  output  ADDR_SIZE  register-file write address.
REQ-017 write_data  output  XLEN  register-file write data.
REQ-018 pending  output  2^ADDR_SIZE  bit i set while any buffered load targets register i.

Function
REQ-019 ALU handshake = alu_valid & alu_ready at a rising edge; mem handshake = mem_valid & mem_ready.
REQ-020 mem_ready SHALL be 1 exactly when the buffer count < FIFO_DEPTH; a pop in the same cycle does not raise it.
REQ-021 A mem handshake SHALL push {mem_rd, mem_data} to the buffer tail on that edge.
REQ-022 Arbitration per edge: ALU handshake wins; otherwise, if the buffer is non-empty, the head SHALL be popped.
REQ-023 The winner's {rd, data} SHALL be registered into write_addr/write_data on that edge, with write_enable = 1 if rd != 0, else 0.
REQ-024 With no winner on an edge, write_enable SHALL be 0 the next cycle; write_addr/write_data hold their previous values.
REQ-025 Latency: ALU result on the write port 1 cycle after its handshake; load result at the earliest 2 cycles after its handshake (push, then pop).
REQ-026 Results with rd = 0 SHALL be consumed (handshaken or popped) but never produce write_enable = 1.
REQ-027 Buffer order SHALL be FIFO; pointers wrap modulo FIFO_DEPTH.
REQ-028 A push and a pop on the same edge SHALL leave the count unchanged, including when the count = FIFO_DEPTH-1.
REQ-029 The starvation counter SHALL increment on each ALU-handshake edge while the buffer is non-empty.
REQ-030 The starvation counter SHALL clear on any pop or while the buffer is empty.
REQ-031 alu_ready SHALL be 1 when the starvation counter < STARVE_LIMIT, else 0, which forces a pop on the next edge.
REQ-032 pending SHALL be combinational from the buffer contents and exclude results already on the write port.
REQ-033 Duplicate rd values in the buffer SHALL be written in order, and the later result is final.

Reset
REQ-034 rst low SHALL immediately empty the buffer, clear the starvation counter, and drive write_enable = 0, write_addr = 0, write_data = 0, pending = 0.
REQ-035 During and after reset, mem_ready = 1 and alu_ready = 1.
REQ-036 Reset asserted mid-operation SHALL discard all buffered results without issuing any write.
REQ-037 The first handshakes SHALL occur on the first rising edge with rst high.

Verification
REQ-038 Single ALU: alu_valid = 1, rd = 5, data = 0xDEADBEEF for one cycle -> next cycle write_enable = 1, addr = 5, data = 0xDEADBEEF; following cycle write_enable = 0.
REQ-039 Single load, ALU idle: mem rd = 7, data = 0x1234 -> pending[7] = 1 for one cycle, write at handshake+2, then pending = 0.
REQ-040 Buffer full: three back-to-back loads (rd 1, 2, 3) while ALU is continuously valid -> mem_ready = 0 after two pushes; rd 3 is held until a pop.
REQ-041 Starvation: buffer holds rd 9 and ALU is valid every cycle -> 4 ALU writes, then alu_ready = 0 for one cycle, rd 9 written, counter cleared.
REQ-042 x0 and reset: ALU rd = 0 -> alu_ready handshake occurs with no write; rst low with 2 buffered loads -> pending = 0 and write_enable = 0 immediately, and no write after release.
